ysyx_220066_dmem_resp: RTL and testbench

- Data-side memory responder: the memory end of the core's load/store interface (MemRd, MemWr, MemOp, addr, data_Wr in; data_Rd, data_Rd_valid, data_Rd_error out).
- Posts stores into a write buffer, because the core never waits on writes.
- Services loads over a 64-bit backing bus after the buffer drains, then aligns and extends the returned data per MemOp.
- Sits between the core and the SoC memory/crossbar.

---
 rtl/ysyx_220066_dmem_resp_pkg.sv | 75 +++++++
 rtl/ysyx_220066_dmem_resp_wbuf.sv | 76 +++++++
 rtl/ysyx_220066_dmem_resp.sv | 141 ++++++++++++++
 tb/tb_ysyx_220066_dmem_resp.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220066_dmem_resp_pkg.sv
// Shared types and helpers for the data-side memory responder:
// MemOp encodings, read FSM states, access sizing, strobes and load extension.
package ysyx_220066_dmem_resp_pkg;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int STRB_W = 8;

   typedef enum logic [2:0] {
      MEM_LB  = 3'b000,
      MEM_LH  = 3'b001,
      MEM_LW  = 3'b010,
      MEM_LD  = 3'b011,
      MEM_LBU = 3'b100,
      MEM_LHU = 3'b101,
      MEM_LWU = 3'b110,
      MEM_INV = 3'b111
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } rd_state_e;

   function automatic logic [3:0] mem_size(input logic [1:0] sz);
      logic [3:0] n;
      case (sz)
         2'b00:   n = 4'd1;
         2'b01:   n = 4'd2;
         2'b10:   n = 4'd4;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
      logic [3:0] m;
      m = mem_size(sz) - 4'd1;
      return |(off & m[2:0]);
   endfunction

   function automatic logic [STRB_W-1:0] strb_gen(input logic [1:0] sz, input logic [2:0] off);
      logic [STRB_W-1:0] base;
      case (sz)
         2'b00:   base = 8'h01;
         2'b01:   base = 8'h03;
         2'b10:   base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << off;
   endfunction

   // Pull the addressed lane down to bit 0, then sign- or zero-extend by MemOp.
   function automatic logic [DATA_W-1:0] lane_extend(input logic [DATA_W-1:0] rdata,
                                                     input logic [2:0]        off,
                                                     input logic [2:0]        op);
      logic [DATA_W-1:0] s;
      logic [DATA_W-1:0] r;
      s = rdata >> {off, 3'b000};
      case (op)
         MEM_LB:  r = {{56{s[7]}}, s[7:0]};
         MEM_LH:  r = {{48{s[15]}}, s[15:0]};
         MEM_LW:  r = {{32{s[31]}}, s[31:0]};
         MEM_LD:  r = s;
         MEM_LBU: r = {56'd0, s[7:0]};
         MEM_LHU: r = {48'd0, s[15:0]};
         MEM_LWU: r = {32'd0, s[31:0]};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ysyx_220066_dmem_resp_wbuf.sv
// Posted-store FIFO: holds {dword address, lane-positioned data, strobes}
// until the bus accepts them, in arrival order.
module ysyx_220066_wbuf
   import ysyx_220066_dmem_resp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [ADDR_W-4:0]       push_addr,
   input  logic [DATA_W-1:0]       push_data,
   input  logic [STRB_W-1:0]       push_strb,
   input  logic                    pop,
   output logic                    full,
   output logic                    empty,
   output logic [ADDR_W-4:0]       head_addr,
   output logic [DATA_W-1:0]       head_data,
   output logic [STRB_W-1:0]       head_strb
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-4:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [STRB_W-1:0] strb_mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   logic push_ok;
   logic pop_ok;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Pointers are PTR_W wide and DEPTH is a power of two, so they wrap on their own.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         addr_mem[wr_ptr_reg] <= push_addr;
         data_mem[wr_ptr_reg] <= push_data;
         strb_mem[wr_ptr_reg] <= push_strb;
      end
   end

   assign head_addr = addr_mem[rd_ptr_reg];
   assign head_data = data_mem[rd_ptr_reg];
   assign head_strb = strb_mem[rd_ptr_reg];

endmodule

// File: rtl/ysyx_220066_dmem_resp.sv
// Memory end of the core's load/store port: posts stores through a write
// buffer and services loads on the 64-bit bus once the buffer has drained.
module ysyx_220066_dmem_resp
   import ysyx_220066_dmem_resp_pkg::*;
#(
   parameter int WBUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRd,
   input  logic              MemWr,
   input  logic [2:0]        MemOp,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_Wr,
   output logic [DATA_W-1:0] data_Rd,
   output logic              data_Rd_valid,
   output logic              data_Rd_error,
   output logic              wbuf_full,
   output logic              wr_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rerr
);

   rd_state_e         state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [2:0]        op_reg;
   logic [DATA_W-1:0] data_reg;
   logic              err_reg;
   logic              wr_err_reg;

   logic              wb_full;
   logic              wb_empty;
   logic [ADDR_W-4:0] wb_head_addr;
   logic [DATA_W-1:0] wb_head_data;
   logic [STRB_W-1:0] wb_head_strb;

   logic              access_misalign;
   logic              ld_bad;
   logic              push_ok;
   logic              wb_pop;
   logic              rd_issue;
   logic              hold_match;

   assign access_misalign = is_misaligned(MemOp[1:0], addr[2:0]);
   assign ld_bad          = access_misalign || (MemOp == MEM_INV);

   // Full is judged on the count at the edge, so a same-cycle pop never frees a slot.
   assign push_ok  = MemWr && !wb_full && !access_misalign;
   assign wb_pop   = !wb_empty && mem_gnt;
   assign rd_issue = (state_reg == ST_REQ) && wb_empty && mem_gnt;

   assign hold_match = MemRd && (addr == addr_reg) && (MemOp == op_reg);

   ysyx_220066_wbuf #(
      .DEPTH (WBUF_DEPTH)
   ) u_wbuf (
      .clk       (clk),
      .rst       (rst),
      .push      (push_ok),
      .push_addr (addr[ADDR_W-1:3]),
      .push_data (data_Wr << {addr[2:0], 3'b000}),
      .push_strb (strb_gen(MemOp[1:0], addr[2:0])),
      .pop       (wb_pop),
      .full      (wb_full),
      .empty     (wb_empty),
      .head_addr (wb_head_addr),
      .head_data (wb_head_data),
      .head_strb (wb_head_strb)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_err_reg <= 1'b0;
      end else if (MemWr && (wb_full || access_misalign)) begin
         wr_err_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         op_reg    <= 3'b000;
         data_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               // A store in the same cycle wins; the load is picked up next cycle.
               if (MemRd && !MemWr) begin
                  addr_reg <= addr;
                  op_reg   <= MemOp;
                  if (ld_bad) begin
                     data_reg  <= '0;
                     err_reg   <= 1'b1;
                     state_reg <= ST_DONE;
                  end else if (wb_empty) begin
                     state_reg <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (rd_issue) state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  data_reg  <= lane_extend(mem_rdata, addr_reg[2:0], op_reg);
                  err_reg   <= mem_rerr;
                  state_reg <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!hold_match) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Drain owns the bus whenever the buffer holds anything.
   assign mem_req   = !wb_empty || (state_reg == ST_REQ);
   assign mem_we    = !wb_empty;
   assign mem_addr  = !wb_empty ? {wb_head_addr, 3'b000} :
                      (state_reg == ST_REQ) ? {addr_reg[ADDR_W-1:3], 3'b000} : '0;
   assign mem_wdata = !wb_empty ? wb_head_data : '0;
   assign mem_wstrb = !wb_empty ? wb_head_strb : '0;

   assign data_Rd_valid = (state_reg == ST_DONE) && hold_match;
   assign data_Rd       = data_Rd_valid ? data_reg : '0;
   assign data_Rd_error = data_Rd_valid && err_reg;
   assign wbuf_full     = wb_full;
   assign wr_err        = wr_err_reg;

endmodule

// File: tb/tb_ysyx_220066_dmem_resp.sv
// Directed bench for the data memory responder with read/write scoreboards.
module tb_ysyx_220066_dmem_resp;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        MemRd = 1'b0;
   logic        MemWr = 1'b0;
   logic [2:0]  MemOp = 3'b000;
   logic [63:0] addr = '0;
   logic [63:0] data_Wr = '0;
   logic [63:0] data_Rd;
   logic        data_Rd_valid;
   logic        data_Rd_error;
   logic        wbuf_full;
   logic        wr_err;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;
   logic        mem_rerr = 1'b0;

   typedef struct packed {
      logic [63:0] d;
      logic        e;
   } rd_exp_t;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] d;
      logic [7:0]  s;
   } wr_exp_t;

   rd_exp_t rd_q[$];
   wr_exp_t wr_q[$];

   int n_checks = 0;
   int n_err    = 0;
   int n_rd     = 0;
   int n_wr     = 0;

   logic        gnt_en = 1'b1;
   logic        hold_rv = 1'b0;
   logic        rd_pend = 1'b0;
   logic [63:0] bus_rdata = '0;
   logic        bus_rerr = 1'b0;
   logic [63:0] exp_rd_addr = '0;

   ysyx_220066_dmem_resp #(.WBUF_DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .MemRd         (MemRd),
      .MemWr         (MemWr),
      .MemOp         (MemOp),
      .addr          (addr),
      .data_Wr       (data_Wr),
      .data_Rd       (data_Rd),
      .data_Rd_valid (data_Rd_valid),
      .data_Rd_error (data_Rd_error),
      .wbuf_full     (wbuf_full),
      .wr_err        (wr_err),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wstrb     (mem_wstrb),
      .mem_gnt       (mem_gnt),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .mem_rerr      (mem_rerr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Write scoreboard: every accepted bus write must match the oldest expected store.
   always @(negedge clk) begin
      if (rst && mem_req && mem_we && mem_gnt) begin
         n_wr++;
         chk("wr_expected", 64'(wr_q.size() > 0), 64'd1);
         if (wr_q.size() > 0) begin
            wr_exp_t w;
            w = wr_q.pop_front();
            chk("wr_addr", mem_addr, w.a);
            chk("wr_data", mem_wdata, w.d);
            chk("wr_strb", {56'd0, mem_wstrb}, {56'd0, w.s});
         end
      end
   end

   // One clock: advance past the edge, then play the bus side for this cycle.
   task automatic cyc();
      logic issue;
      @(posedge clk);
      #1;
      MemWr      = 1'b0;
      mem_rvalid = rd_pend && !hold_rv;
      mem_rdata  = mem_rvalid ? bus_rdata : 64'd0;
      mem_rerr   = mem_rvalid && bus_rerr;
      if (mem_rvalid) rd_pend = 1'b0;
      mem_gnt = gnt_en && mem_req;
      issue   = mem_gnt && !mem_we;
      if (issue) begin
         rd_pend = 1'b1;
         n_rd++;
         chk("rd_addr", mem_addr, exp_rd_addr);
         chk("rd_after_wr", 64'(wr_q.size()), 64'd0);
      end
   endtask

   task automatic store(input logic [2:0] op, input logic [63:0] a, input logic [63:0] d,
                        input bit accept);
      wr_exp_t w;
      logic [7:0] base;
      cyc();
      MemWr   = 1'b1;
      MemOp   = op;
      addr    = a;
      data_Wr = d;
      case (op[1:0])
         2'b00:   base = 8'h01;
         2'b01:   base = 8'h03;
         2'b10:   base = 8'h0F;
         default: base = 8'hFF;
      endcase
      w.a = {a[63:3], 3'b000};
      w.d = d << (8 * a[2:0]);
      w.s = base << a[2:0];
      if (accept) wr_q.push_back(w);
   endtask

   task automatic load(input logic [2:0] op, input logic [63:0] a, input logic [63:0] rdata,
                       input logic rerr, input logic [63:0] exp_d, input logic exp_e,
                       input int exp_lat, input bit chk_d);
      int lat;
      rd_exp_t e;
      cyc();
      MemRd       = 1'b1;
      MemOp       = op;
      addr        = a;
      bus_rdata   = rdata;
      bus_rerr    = rerr;
      exp_rd_addr = {a[63:3], 3'b000};
      rd_q.push_back('{d: exp_d, e: exp_e});
      lat = 0;
      #2;
      while (!data_Rd_valid && lat < 40) begin
         cyc();
         lat++;
         #2;
      end
      chk("ld_latency", 64'(lat), 64'(exp_lat));
      chk("ld_valid", {63'd0, data_Rd_valid}, 64'd1);
      e = rd_q.pop_front();
      if (chk_d) chk("ld_data", data_Rd, e.d);
      chk("ld_error", {63'd0, data_Rd_error}, {63'd0, e.e});
      $display("load op=%0d addr=%0h -> data=%0h err=%0b lat=%0d", op, a, data_Rd, data_Rd_error, lat);
   endtask

   task automatic release_rd();
      cyc();
      MemRd = 1'b0;
      #2;
      chk("drop_valid", {63'd0, data_Rd_valid}, 64'd0);
   endtask

   initial begin
      int rd0;
      int wr0;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {63'd0, data_Rd_valid}, 64'd0);
      chk("rst_data", data_Rd, 64'd0);
      chk("rst_req", {63'd0, mem_req}, 64'd0);
      chk("rst_full", {63'd0, wbuf_full}, 64'd0);
      chk("rst_wr_err", {63'd0, wr_err}, 64'd0);
      cyc();
      rst = 1'b1;

      // Aligned loads, including op/addr changes while MemRd stays high
      load(3'b010, 64'h1004, 64'h8000_0001_DEAD_BEEF, 1'b0, 64'hFFFF_FFFF_8000_0001, 1'b0, 3, 1);
      load(3'b110, 64'h1004, 64'h8000_0001_DEAD_BEEF, 1'b0, 64'h0000_0000_8000_0001, 1'b0, 4, 1);
      load(3'b000, 64'h1007, 64'h8000_0001_DEAD_BEEF, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 4, 1);
      load(3'b101, 64'h1002, 64'h8000_0001_DEAD_BEEF, 1'b0, 64'h0000_0000_0000_DEAD, 1'b0, 4, 1);
      release_rd();

      // Store followed immediately by a load of the same dword
      rd0 = n_rd;
      store(3'b011, 64'h2000, 64'h1122_3344_5566_7788, 1);
      load(3'b011, 64'h2000, 64'h1122_3344_5566_7788, 1'b0, 64'h1122_3344_5566_7788, 1'b0, 4, 1);
      chk("st_ld_rd_count", 64'(n_rd - rd0), 64'd1);
      release_rd();

      // Hold after completion: result stays, no second bus read
      rd0 = n_rd;
      load(3'b011, 64'h5000, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 1);
      for (int k = 0; k < 5; k++) begin
         cyc();
         #2;
         chk("hold_valid", {63'd0, data_Rd_valid}, 64'd1);
         chk("hold_data", data_Rd, 64'h0123_4567_89AB_CDEF);
      end
      chk("hold_rd_count", 64'(n_rd - rd0), 64'd1);
      load(3'b010, 64'h5008, 64'h0000_0000_7FFF_0000, 1'b1, 64'h0000_0000_7FFF_0000, 1'b1, 4, 1);
      release_rd();

      // Misaligned and invalid loads never reach the bus
      rd0 = n_rd;
      load(3'b001, 64'h3001, 64'd0, 1'b0, 64'd0, 1'b1, 1, 0);
      release_rd();
      load(3'b111, 64'h3000, 64'd0, 1'b0, 64'd0, 1'b1, 1, 0);
      release_rd();
      chk("misalign_rd_count", 64'(n_rd - rd0), 64'd0);
      chk("wr_err_before", {63'd0, wr_err}, 64'd0);
      store(3'b010, 64'h3002, 64'h0000_0000_DEAD_BEEF, 0);
      cyc();
      #2;
      $display("store misaligned sw addr=3002 -> wr_err=%0b mem_req=%0b", wr_err, mem_req);
      chk("st_misalign_wr_err", {63'd0, wr_err}, 64'd1);
      chk("st_misalign_nopush", {63'd0, mem_req}, 64'd0);

      // Reset while waiting for read data; the late rvalid must be ignored
      cyc();
      MemRd       = 1'b1;
      MemOp       = 3'b010;
      addr        = 64'h6000;
      exp_rd_addr = 64'h6000;
      bus_rdata   = 64'hBAD0_BAD0_BAD0_BAD0;
      bus_rerr    = 1'b0;
      hold_rv     = 1'b1;
      cyc();
      cyc();
      #2;
      rst = 1'b0;
      #1;
      chk("arst_req", {63'd0, mem_req}, 64'd0);
      chk("arst_valid", {63'd0, data_Rd_valid}, 64'd0);
      chk("arst_data", data_Rd, 64'd0);
      chk("arst_addr", mem_addr, 64'd0);
      chk("arst_wr_err", {63'd0, wr_err}, 64'd0);
      MemRd = 1'b0;
      cyc();
      rst     = 1'b1;
      hold_rv = 1'b0;
      cyc();
      #2;
      chk("late_rvalid_req", {63'd0, mem_req}, 64'd0);
      cyc();
      #2;
      chk("late_rvalid_valid", {63'd0, data_Rd_valid}, 64'd0);
      rd0 = n_rd;
      load(3'b010, 64'h6000, 64'h0000_0000_1234_5678, 1'b0, 64'h0000_0000_1234_5678, 1'b0, 3, 1);
      chk("fresh_rd_count", 64'(n_rd - rd0), 64'd1);
      release_rd();

      // Overflow with the bus stalled, then drain in order
      gnt_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         store(3'b000, 64'h4000 + 64'(i), 64'h10 + 64'(i), i < 4);
         #2;
         $display("store sb addr=%0h full=%0b", addr, wbuf_full);
         chk("ovf_full", {63'd0, wbuf_full}, {63'd0, (i == 4)});
      end
      cyc();
      #2;
      chk("ovf_wr_err", {63'd0, wr_err}, 64'd1);
      chk("ovf_still_full", {63'd0, wbuf_full}, 64'd1);
      gnt_en = 1'b1;
      wr0 = n_wr;
      for (int k = 0; k < 20 && mem_req; k++) begin
         cyc();
         #2;
      end
      chk("ovf_drain_count", 64'(n_wr - wr0), 64'd4);
      chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
      chk("drain_not_full", {63'd0, wbuf_full}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
